// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS iterative divider.
package mips_div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FIX
  } state_e;

endpackage

// File: rtl/mips_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             qmsb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry keeps the WIDTH+1 bit trial sign unambiguous
  always_comb begin
    shifted = {rem_i, qmsb_i};
    trial   = shifted - {1'b0, divisor_i};
    qbit_o  = ~trial[WIDTH];
    rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_divider.sv
// Iterative restoring divider (DIV/DIVU) producing LO/HI after WIDTH+1 cycles.
// Signed support is built only when MIPS_DIV_SIGNED_EN is defined; otherwise every op is DIVU.
module mips_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d, dvnd_q, dvnd_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  assign accept = (state_q == IDLE) && start;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .qmsb_i    (quo_q[WIDTH-1]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_bit)
  );

`ifdef MIPS_DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic qneg_q, qneg_d, rneg_q, rneg_d;

  assign a_neg  = is_signed & dividend[WIDTH-1];
  assign b_neg  = is_signed & divisor[WIDTH-1];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor : divisor;
  assign qneg_d = accept ? (a_neg ^ b_neg) : qneg_q;
  assign rneg_d = accept ? a_neg : rneg_q;
  // Remainder sign follows the dividend; 0x80000000/-1 wraps back to 0x80000000
  assign q_fix  = qneg_q ? -quo_q : quo_q;
  assign r_fix  = rneg_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end
`else
  logic unused_sign;

  assign unused_sign = is_signed;
  assign a_mag       = dividend;
  assign b_mag       = divisor;
  assign q_fix       = quo_q;
  assign r_fix       = rem_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    dvnd_d      = dvnd_q;
    dz_d        = dz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DIVIDE;
          busy_d  = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvsr_d  = b_mag;
          dvnd_d  = dividend;
          dz_d    = (divisor == '0);
        end
      end
      DIVIDE: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        // Divide by zero reports the raw dividend, with no sign correction
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dvnd_q;
        end else begin
          quotient_d  = q_fix;
          remainder_d = r_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Working registers are always initialised on accept, so they carry no reset
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvsr_q <= dvsr_d;
    dvnd_q <= dvnd_d;
    dz_q   <= dz_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_divider.sv
// Scoreboard bench for mips_divider: stimulus pushes expected results, a monitor checks each done pulse.
module tb_mips_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic [31:0] acc;
    logic [7:0]  id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mips_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=q:%h r:%h required=no done", quotient, remainder);
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d_quotient", e.id), quotient, e.q);
        chk($sformatf("op%0d_remainder", e.id), remainder, e.r);
        chk($sformatf("op%0d_div_by_zero", e.id), {31'd0, div_by_zero}, {31'd0, e.dz});
        chk($sformatf("op%0d_latency", e.id), cyc - int'(e.acc), 32'd33);
      end
    end
  end

  // Call at a negedge; the following posedge is the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       input logic [7:0] id, input bit push);
    exp_t e;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dz  = ez;
      e.acc = cyc + 1;
      e.id  = id;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("op%0d_busy_after_accept", id), {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no done required=done within 200 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;

    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 8'd1, 1'b1);
    wait_done("op1");

`ifdef MIPS_DIV_SIGNED_EN
    @(negedge clk);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 8'd2, 1'b1);
    wait_done("op2");
    @(negedge clk);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 8'd3, 1'b1);
    wait_done("op3");
    @(negedge clk);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 8'd4, 1'b1);
    wait_done("op4");
`else
    @(negedge clk);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 8'd2, 1'b1);
    wait_done("op2");
    @(negedge clk);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 8'd3, 1'b1);
    wait_done("op3");
    @(negedge clk);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, 8'd4, 1'b1);
    wait_done("op4");
`endif

    @(negedge clk);
    issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 8'd5, 1'b1);
    wait_done("op5");
    @(negedge clk);
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 8'd6, 1'b1);
    wait_done("op6");

    // A start while busy must be dropped without disturbing the op in flight
    @(negedge clk);
    issue(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b0, 8'd7, 1'b1);
    repeat (8) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_ignored_start", {31'd0, busy}, 32'd1);
    wait_done("op7");
    issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 8'd8, 1'b1);
    wait_done("op8");

    // Asynchronous abort mid-operation
    @(negedge clk);
    issue(32'd123, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0, 8'd9, 1'b0);
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 8'd10, 1'b1);
    wait_done("op10");

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
